// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and frame-size helper for the UART transceiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic int frame_bits(input int dw, input int pm, input int sb);
    return 1 + dw + ((pm != PARITY_NONE) ? 1 : 0) + sb;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable baud prescaler: counts 0..div and ticks on the terminal count.
// The divisor is latched on restart so a mid-frame change cannot disturb timing.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q + 1'b1;
    if (restart_i) begin
      div_d = div_i;
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  // Not gated by restart: the Tx back-to-back accept depends on this tick.
  assign tick_o = (cnt_q == div_q);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: PISO transmitter plus oversampling receiver with glitch
// rejection, framing/break detection and internal loopback.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  loopback,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_is_valid,
  output logic                  rx_error,
  output logic                  framing_error,
  output logic                  break_detect
);

  localparam int FRAME_BITS = frame_bits(DATA_WIDTH, PARITY_MODE, STOP_BITS);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(FRAME_BITS);
  localparam int RXC_W = $clog2(DATA_WIDTH);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0]  TX_LAST = BC_W'(FRAME_BITS - 1);
  localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(DATA_WIDTH - 1);

  // ---------------- Transmitter ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [FRAME_BITS-1:0] tx_frame, tx_sh_q;
  logic [OS_W-1:0]       tx_os_q;
  logic [BC_W-1:0]       tx_bit_q;
  logic                  serial_out_q;
  logic                  tx_tick, tx_accept, tx_shift, tx_bit_end;

  always_comb begin
    tx_frame    = '1;
    tx_frame[0] = 1'b0;
    tx_frame[DATA_WIDTH:1] = i_data;
    if (PARITY_MODE != PARITY_NONE)
      tx_frame[DATA_WIDTH+1] = (PARITY_MODE == PARITY_EVEN) ? ^i_data : ~^i_data;
  end

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tx_baud (
    .clk       (clk),
    .reset     (reset),
    .restart_i (tx_accept),
    .div_i     (baud_div),
    .tick_o    (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_accept  = 1'b0;
    tx_shift   = 1'b0;
    tx_bit_end = tx_tick && (tx_os_q == OS_LAST);
    case (tx_state_q)
      TX_IDLE: begin
        if (enable) begin
          tx_accept  = 1'b1;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_bit_end) begin
          if (tx_bit_q == TX_LAST) begin
            if (enable) tx_accept  = 1'b1;
            else        tx_state_d = TX_IDLE;
          end else begin
            tx_shift = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_sh_q      <= '1;
      tx_os_q      <= '0;
      tx_bit_q     <= '0;
      serial_out_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      if (tx_accept) begin
        // Start bit goes straight to the line; the rest waits in the shifter.
        tx_sh_q      <= tx_frame >> 1;
        serial_out_q <= 1'b0;
        tx_bit_q     <= '0;
        tx_os_q      <= '0;
      end else begin
        if (tx_state_q == TX_SHIFT && tx_tick)
          tx_os_q <= tx_bit_end ? '0 : tx_os_q + 1'b1;
        if (tx_shift) begin
          serial_out_q <= tx_sh_q[0];
          tx_sh_q      <= {1'b1, tx_sh_q[FRAME_BITS-1:1]};
          tx_bit_q     <= tx_bit_q + 1'b1;
        end else if (tx_state_d == TX_IDLE) begin
          serial_out_q <= 1'b1;
        end
      end
    end
  end

  assign serial_out = serial_out_q;
  assign o_busy     = (tx_state_q == TX_SHIFT);

  // ---------------- Receiver ----------------
  rx_state_e             rx_state_q, rx_state_d;
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                  rx_pin, rx_sync, rx_prev_q, rx_fall;
  logic                  rx_tick, rx_restart, rx_mid, rx_report;
  logic [OS_W-1:0]       rx_os_q;
  logic [RXC_W-1:0]      rx_bit_q;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_data_q;
  logic                  rx_par_q, rx_any_one_q, rx_par_exp;
  logic                  dv_q, perr_q, ferr_q, brk_q;

  assign rx_pin  = loopback ? serial_out_q : serial_in;
  assign rx_sync = rx_sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q & ~rx_sync;
  assign rx_par_exp = (PARITY_MODE == PARITY_EVEN) ? ^rx_sh_q : ~^rx_sh_q;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_rx_baud (
    .clk       (clk),
    .reset     (reset),
    .restart_i (rx_restart),
    .div_i     (baud_div),
    .tick_o    (rx_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_restart = 1'b0;
    rx_report  = 1'b0;
    // Start bit is sampled after half a bit; all later bits a full bit apart.
    rx_mid = rx_tick && (rx_os_q == ((rx_state_q == RX_START) ? OS_HALF : OS_LAST));
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_restart = 1'b1;
          rx_state_d = RX_START;
        end
      end
      RX_START:  if (rx_mid) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_mid && rx_bit_q == RX_LAST)
          rx_state_d = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_mid) rx_state_d = RX_STOP;
      RX_STOP: begin
        if (rx_mid) begin
          rx_report  = 1'b1;
          rx_state_d = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_sync) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_sync_q    <= '1;
      rx_prev_q    <= 1'b1;
      rx_os_q      <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_par_q     <= 1'b0;
      rx_any_one_q <= 1'b0;
      rx_data_q    <= '0;
      dv_q         <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], rx_pin};
      rx_prev_q  <= rx_sync;
      rx_state_q <= rx_state_d;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      if (rx_restart) begin
        rx_os_q      <= '0;
        rx_bit_q     <= '0;
        rx_any_one_q <= 1'b0;
      end else if (rx_tick && rx_state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
        rx_os_q <= rx_mid ? '0 : rx_os_q + 1'b1;
      end
      if (rx_mid && rx_state_q == RX_DATA) begin
        rx_sh_q      <= {rx_sync, rx_sh_q[DATA_WIDTH-1:1]};
        rx_bit_q     <= rx_bit_q + 1'b1;
        rx_any_one_q <= rx_any_one_q | rx_sync;
      end
      if (rx_mid && rx_state_q == RX_PARITY) begin
        rx_par_q     <= rx_sync;
        rx_any_one_q <= rx_any_one_q | rx_sync;
      end
      if (rx_report) begin
        rx_data_q <= rx_sh_q;
        dv_q      <= 1'b1;
        perr_q    <= (PARITY_MODE != PARITY_NONE) && (rx_par_q != rx_par_exp);
        ferr_q    <= ~rx_sync;
        brk_q     <= ~rx_sync & ~rx_any_one_q;
      end
    end
  end

  assign received_data = rx_data_q;
  assign data_is_valid = dv_q;
  assign rx_error      = perr_q;
  assign framing_error = ferr_q;
  assign break_detect  = brk_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench: loopback Tx timing, table-driven external Rx frames,
// glitch/break/back-to-back/reset corner sequences, scoreboarded Rx results.
module tb_uart_xcvr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        loopback = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  i_data = '0;
  logic        o_busy, serial_out;
  logic        sin_a = 1'b1, sin_b = 1'b1;
  logic [7:0]  rd_a, rd_b;
  logic        dv_a, pe_a, fe_a, bk_a;
  logic        dv_b, pe_b, fe_b, bk_b;
  logic        busy_b, so_b;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe, fe, bk;
    int         cyc;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    int         div;
    logic [7:0] exp_data;
    logic       exp_pe, exp_fe, exp_bk;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_xcvr u_a (
    .clk(clk), .reset(reset), .baud_div(baud_div), .loopback(loopback),
    .enable(enable), .i_data(i_data), .o_busy(o_busy), .serial_out(serial_out),
    .serial_in(sin_a), .received_data(rd_a), .data_is_valid(dv_a),
    .rx_error(pe_a), .framing_error(fe_a), .break_detect(bk_a)
  );

  uart_xcvr #(.PARITY_MODE(2)) u_b (
    .clk(clk), .reset(reset), .baud_div(baud_div), .loopback(1'b0),
    .enable(1'b0), .i_data(8'h00), .o_busy(busy_b), .serial_out(so_b),
    .serial_in(sin_b), .received_data(rd_b), .data_is_valid(dv_b),
    .rx_error(pe_b), .framing_error(fe_b), .break_detect(bk_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard consumers for both receivers.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && dv_a) begin
      checks++;
      if (qa.size() == 0) begin
        errs++;
        $display("FAIL rx_a_unexpected: data=%h pe=%b fe=%b bk=%b cycle %0d", rd_a, pe_a, fe_a, bk_a, cyc);
      end else begin
        e = qa.pop_front();
        if ({rd_a, pe_a, fe_a, bk_a} !== {e.d, e.pe, e.fe, e.bk} || (e.cyc != 0 && cyc != e.cyc)) begin
          errs++;
          $display("FAIL rx_a: got data=%h pe=%b fe=%b bk=%b cyc=%0d expected data=%h pe=%b fe=%b bk=%b cyc=%0d",
                   rd_a, pe_a, fe_a, bk_a, cyc, e.d, e.pe, e.fe, e.bk, e.cyc);
        end
      end
    end
    if (!reset && dv_b) begin
      checks++;
      if (qb.size() == 0) begin
        errs++;
        $display("FAIL rx_b_unexpected: data=%h cycle %0d", rd_b, cyc);
      end else begin
        e = qb.pop_front();
        if ({rd_b, pe_b, fe_b, bk_b} !== {e.d, e.pe, e.fe, e.bk}) begin
          errs++;
          $display("FAIL rx_b: got data=%h pe=%b fe=%b bk=%b expected data=%h pe=%b fe=%b bk=%b",
                   rd_b, pe_b, fe_b, bk_b, e.d, e.pe, e.fe, e.bk);
        end
      end
    end
  end

  task automatic drive_bit(input bit which, input logic v, input int n);
    if (which) sin_b = v; else sin_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_ext(input bit which, input logic [7:0] d, input logic pbit,
                          input logic stopv, input int div);
    int n;
    n = 8 * (div + 1);
    drive_bit(which, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], n);
    drive_bit(which, pbit, n);
    drive_bit(which, stopv, n);
    drive_bit(which, 1'b1, 2 * n);
  endtask

  // Loopback transmit with frame-edge timing checks; Rx result via scoreboard.
  task automatic lb_send(input logic [7:0] d);
    int t0;
    @(negedge clk);
    i_data = d; enable = 1'b1; t0 = cyc;
    qa.push_back('{d, 1'b0, 1'b0, 1'b0, t0 + 341});
    for (int k = 1; k <= 353; k++) begin
      @(negedge clk);
      enable = 1'b0;
      if (k == 1 || k == 32) chk("tx_start_bit", serial_out, 0);
      if (k == 33)  chk("tx_bit0", serial_out, d[0]);
      if (k == 352) chk("busy_hold", o_busy, 1);
      if (k == 353) chk("busy_fall", o_busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   t0;
    vt[0] = '{8'h3C, 1'b0, 1'b1, 3, 8'h3C, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h00, 1'b0, 1'b1, 3, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 1'b1, 3, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'h81, 1'b0, 1'b0, 3, 8'h81, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h5A, 1'b0, 1'b1, 0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'hC7, 1'b1, 1'b0, 1, 8'hC7, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_serial_out", serial_out, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_rdata", rd_a, 0);
    chk("rst_flags", {dv_a, pe_a, fe_a, bk_a}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_serial_out", serial_out, 1);

    // Loopback 0xA5, baud_div=3
    loopback = 1'b1;
    baud_div = 16'd3;
    lb_send(8'hA5);

    // enable held across two frames: back-to-back, data change while busy ignored
    @(negedge clk);
    i_data = 8'h01; enable = 1'b1; t0 = cyc;
    qa.push_back('{8'h01, 1'b0, 1'b0, 1'b0, t0 + 341});
    qa.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, t0 + 693});
    for (int k = 1; k <= 706; k++) begin
      @(negedge clk);
      if (k == 1) i_data = 8'hFF;
      if (k == 353) enable = 1'b0;
      if (k == 65)  chk("b2b_f1_bit1", serial_out, 0);
      if (k == 352) chk("b2b_stop", serial_out, 1);
      if (k == 353) chk("b2b_start2", {o_busy, serial_out}, 2'b10);
      if (k == 417) chk("b2b_f2_bit1", serial_out, 1);
      if (k == 705) chk("b2b_busy_fall", o_busy, 0);
    end

    // enable pulse mid-frame ignored
    @(negedge clk);
    i_data = 8'h5A; enable = 1'b1; t0 = cyc;
    qa.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, t0 + 341});
    for (int k = 1; k <= 360; k++) begin
      @(negedge clk);
      enable = (k == 100);
      if (k == 100) i_data = 8'h33;
      if (k == 353) chk("ign_busy_fall", o_busy, 0);
      if (k == 360) chk("ign_idle", {o_busy, serial_out}, 2'b01);
    end

    // Reset during data bit 4
    @(negedge clk);
    i_data = 8'hC3; enable = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      enable = 1'b0;
    end
    chk("pre_rst_busy", o_busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_line", serial_out, 1);
    chk("rst_mid_busy", o_busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    lb_send(8'h96);

    // Table of external frames into u_a
    loopback = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      baud_div = 16'(vt[i].div);
      qa.push_back('{vt[i].exp_data, vt[i].exp_pe, vt[i].exp_fe, vt[i].exp_bk, 0});
      send_ext(1'b0, vt[i].data, (^vt[i].data) ^ vt[i].par_flip, vt[i].stop, vt[i].div);
    end

    // Odd-parity receiver fed an even-parity frame
    baud_div = 16'd3;
    qb.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 0});
    send_ext(1'b1, 8'h3C, ^(8'h3C), 1'b1, 3);

    // Short glitch rejected, next frame received
    sin_a = 1'b0;
    repeat (3) @(negedge clk);
    sin_a = 1'b1;
    repeat (64) @(negedge clk);
    qa.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 0});
    send_ext(1'b0, 8'h55, ^(8'h55), 1'b1, 3);

    // Break: 20 bit times low -> one report only
    qa.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 0});
    sin_a = 1'b0;
    repeat (640) @(negedge clk);
    chk("break_single", qa.size(), 0);
    sin_a = 1'b1;
    repeat (64) @(negedge clk);
    qa.push_back('{8'hAA, 1'b0, 1'b0, 1'b0, 0});
    send_ext(1'b0, 8'hAA, ^(8'hAA), 1'b1, 3);

    for (int i = 0; i < 2000 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("sb_a_drained", qa.size(), 0);
    chk("sb_b_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: a PISO transmitter and an oversampling receiver, each with its own restartable baud prescaler. Data width, parity mode, stop-bit count, oversampling ratio and synchroniser depth are parameters; the bit rate is a runtime divisor. It adds glitch rejection, framing-error and break detection, and an internal loopback mode. It sits between the system bus logic and the pads, replacing the fixed 8-bit, fixed-rate UART.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal values are 5..9.
- `PARITY_MODE`, 1: parity selection; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits transmitted; 1 or 2.
- `OVERSAMPLE`, 8: prescaler ticks per bit; even, at least 4.
- `DIV_WIDTH`, 16: width of `baud_div`.
- `SYNC_STAGES`, 3: depth of the Rx flip-flop synchroniser; at least 2.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `baud_div`  in  DIV_WIDTH  clocks per tick, minus 1.
- `loopback`  in  1  1 = Rx input taken from internal `serial_out`; the `serial_in` pin is ignored.
- `enable`  in  1  Tx request; accepted only when `o_busy`=0.
- `i_data`  in  DATA_WIDTH  Tx payload, captured at accept.
- `o_busy`  out  1  Tx frame in progress.
- `serial_out`  out  1  Tx line, registered, idle high.
- `serial_in`  in  1  Rx line, asynchronous.
- `received_data`  out  DATA_WIDTH  last received payload.
- `data_is_valid`  out  1  one-cycle pulse per completed Rx frame.
- `rx_error`  out  1  parity error; pulses together with `data_is_valid`.
- `framing_error`  out  1  stop bit sampled as 0; pulses together with `data_is_valid`.
- `break_detect`  out  1  break frame received; pulses together with `data_is_valid`.

## Operation
- Derived values:
  - `BIT_CLKS` = OVERSAMPLE*(baud_div+1).
  - `FRAME_BITS` = 1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS.
  - Parity bit = ^data for even, ~^data for odd.
- Prescaler: counts 0..baud_div and emits a tick when the count equals baud_div. It latches `baud_div` on restart, so a `baud_div` change never affects an in-flight frame.
- Tx states:
  - IDLE: `serial_out`=1. An accept (`enable`=1 while `o_busy`=0) loads the shift register {stop(s), parity, data, 0}, restarts the Tx prescaler and moves to SHIFT.
  - SHIFT: each bit is held for OVERSAMPLE ticks, LSB first.
  - After the last stop bit, return to IDLE. If `enable` is high in that same cycle it is accepted, so frames go back-to-back with no idle gap.
  - `enable` while busy is ignored, not queued.
- Rx states:
  - IDLE: a synchronised 1→0 transition restarts the Rx prescaler and moves to START.
  - START: at OVERSAMPLE/2 ticks, sample the line. If it is 1, treat it as a glitch and return to IDLE without reporting.
  - DATA, then PARITY (only when parity is enabled): sample every OVERSAMPLE ticks at mid-bit.
  - STOP: sample the first stop bit only.
    - In the following cycle, update `received_data`, pulse `data_is_valid`, and pulse the relevant error flags.
    - `rx_error` = parity mismatch (always 0 when PARITY_MODE=0).
    - `framing_error` = stop bit sampled as 0.
    - `break_detect` = all data bits, the parity bit and the stop bit sampled as 0.
  - WAIT_HIGH: entered after a framing error. Stay until the synchronised line is 1, then go to IDLE. This prevents a break from retriggering.
- Loopback: `serial_out` is still driven to the pin; Rx sees `serial_out` through the synchroniser.

## Timing
- Reset values: `serial_out`=1, `o_busy`=0, `received_data`=0, `data_is_valid`=`rx_error`=`framing_error`=`break_detect`=0. Both FSMs are in IDLE and both prescalers are at 0.
- Reset mid-frame aborts both directions immediately (asynchronous); no partial frame is reported.
- Tx: accept in cycle T gives `serial_out`=0 and `o_busy`=1 from T+1. Each bit lasts exactly `BIT_CLKS` cycles. `o_busy` falls at T+1+FRAME_BITS*BIT_CLKS.
- Rx: a line edge is first seen in IDLE in cycle D, which is SYNC_STAGES cycles after the pin change. Bit k is sampled at D + k*BIT_CLKS + BIT_CLKS/2. `data_is_valid` rises one cycle after the stop-bit sample.
- `baud_div`=0 is legal and gives `BIT_CLKS` = OVERSAMPLE.

## Structure
- Package `uart_pkg`:
  - PARITY_NONE/EVEN/ODD constants.
  - Tx and Rx state encodings.
  - Function computing FRAME_BITS.
- Sub-module `uart_baud_tick` (restart input, latched divisor, tick output), instantiated once for Tx and once for Rx.

## Test plan
- Defaults, `baud_div`=3, `loopback`=1, send 0xA5 at cycle T:
  - `serial_out`=0 during T+1..T+32.
  - `o_busy` falls at T+353.
  - `data_is_valid` at T+341 with `received_data`=0xA5 and all error flags 0.
- PARITY_MODE=2, external frame 0x3C sent with even parity: `data_is_valid` and `rx_error` pulse together with `received_data`=0x3C; `framing_error`=0.
- `serial_in` low for 3 clocks with `baud_div`=3 (< `BIT_CLKS`/2 = 16) → no `data_is_valid`; Rx back in IDLE and correctly receives the next frame 0x55.
- `serial_in` held low for 20 bit times → exactly one pulse of `data_is_valid`+`framing_error`+`break_detect` with `received_data`=0x00; nothing further until the line returns high.
- `enable` held high across two frames (0x01, then 0xFF) → second start bit immediately follows the first stop bit; `enable` pulses while busy are ignored.
- `reset` asserted during data bit 4 → `serial_out`=1 and `o_busy`=0 immediately; no `data_is_valid`; the next accepted frame transmits correctly.
